// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared time-of-day definitions for the clock core, the alarm
//                comparator and the display. Packed time layout:
//                [16:12] hours 0-23, [11:6] minutes 0-59, [5:0] seconds 0-59.
//                Provides field widths, field limits, slice positions, a
//                packed struct matching the bus layout and a validity check.
//  Revision    : 1.0  initial release
// ============================================================================
package clock_pkg;

    localparam int TIME_W = 17;
    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

    // Field slice positions within the packed time bus
    localparam int SEC_LSB  = 0;
    localparam int SEC_MSB  = SEC_LSB + SEC_W - 1;
    localparam int MIN_LSB  = SEC_MSB + 1;
    localparam int MIN_MSB  = MIN_LSB + MIN_W - 1;
    localparam int HOUR_LSB = MIN_MSB + 1;
    localparam int HOUR_MSB = HOUR_LSB + HOUR_W - 1;

    // Member order matches the bus layout, hours in the MSBs
    typedef struct packed {
        logic [HOUR_W-1:0] hours;
        logic [MIN_W-1:0]  mins;
        logic [SEC_W-1:0]  secs;
    } time_t;

    // True when every field of a packed time is within its legal range
    function automatic logic time_valid(input logic [TIME_W-1:0] t);
        return (t[HOUR_MSB:HOUR_LSB] <= HOUR_MAX) &&
               (t[MIN_MSB:MIN_LSB]   <= MIN_MAX)  &&
               (t[SEC_MSB:SEC_LSB]   <= SEC_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/time_counter_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : 1 Hz prescaler. Counts 0..CLK_FREQ-1 while en is high and
//                flags the terminal count combinationally so the parent can
//                advance time on the same edge the counter wraps.
//  Ports       : clk      - system clock
//                rst      - asynchronous active-high reset
//                en       - count enable; low freezes the count
//                clear    - synchronous clear, overrides en
//                terminal - high while the count sits at CLK_FREQ-1 and en=1
//  Revision    : 1.0  initial release
// ============================================================================
module tick_gen #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic terminal
);

    localparam int               CNT_W = $clog2(CLK_FREQ);
    localparam logic [CNT_W-1:0] TC    = CNT_W'(CLK_FREQ - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign terminal = en && (count_q == TC);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = terminal ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : time_counter
//  Description : Free-running hh:mm:ss time-of-day core. Divides clk to 1 Hz
//                via tick_gen and keeps the packed time bus. Accepts a
//                validated time load and, when built with CLOCK_ADJUST_EN,
//                minute/hour push-button adjust.
//                Same-edge priority: rst > valid load > adjust > advance.
//  Config      : CLOCK_ADJUST_EN - enables inc_min/inc_hour edge-detected
//                adjust; otherwise those inputs are ignored.
//  Ports       : clk, rst        - clock, async active-high reset
//                en              - run enable (loads/adjusts still work)
//                set_time        - load time_set_in on this edge if valid
//                time_set_in[16:0] - packed time to load
//                inc_min/inc_hour  - adjust buttons (debounced)
//                time_out[16:0]  - current packed time, registered
//                sec_tick        - pulse with each counted seconds update
//                day_tick        - pulse with 23:59:59 -> 00:00:00
//  Revision    : 1.0  initial release
// ============================================================================
module time_counter
    import clock_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              set_time,
    input  logic [TIME_W-1:0] time_set_in,
    input  logic              inc_min,
    input  logic              inc_hour,
    output logic [TIME_W-1:0] time_out,
    output logic              sec_tick,
    output logic              day_tick
);

    time_t time_q;
    time_t time_d;
    time_t load_val;
    logic  sec_tick_q;
    logic  sec_tick_d;
    logic  day_tick_q;
    logic  day_tick_d;
    logic  load_ok;
    logic  tc;
    logic  min_rise;
    logic  hour_rise;

    assign load_val = time_t'(time_set_in);
    assign load_ok  = set_time && time_valid(time_set_in);

    // A valid load restarts the second so the first tick lands CLK_FREQ later
    tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clear    (load_ok),
        .terminal (tc)
    );

`ifdef CLOCK_ADJUST_EN
    logic inc_min_q;
    logic inc_hour_q;

    // Edge detect: one increment per press regardless of hold time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_min_q  <= 1'b0;
            inc_hour_q <= 1'b0;
        end else begin
            inc_min_q  <= inc_min;
            inc_hour_q <= inc_hour;
        end
    end

    assign min_rise  = inc_min  && !inc_min_q;
    assign hour_rise = inc_hour && !inc_hour_q;
`else
    logic unused_adjust;

    assign unused_adjust = inc_min ^ inc_hour;
    assign min_rise      = 1'b0;
    assign hour_rise     = 1'b0;
`endif

    always_comb begin
        time_d     = time_q;
        sec_tick_d = 1'b0;
        day_tick_d = 1'b0;
        if (load_ok) begin
            time_d = load_val;
        end else if (min_rise || hour_rise) begin
            // Adjust pre-empts the seconds advance; minutes never carry here
            if (min_rise) begin
                time_d.mins = (time_q.mins == MIN_MAX) ? '0 : time_q.mins + 1'b1;
            end
            if (hour_rise) begin
                time_d.hours = (time_q.hours == HOUR_MAX) ? '0 : time_q.hours + 1'b1;
            end
        end else if (tc) begin
            sec_tick_d = 1'b1;
            if (time_q.secs == SEC_MAX) begin
                time_d.secs = '0;
                if (time_q.mins == MIN_MAX) begin
                    time_d.mins = '0;
                    if (time_q.hours == HOUR_MAX) begin
                        time_d.hours = '0;
                        day_tick_d   = 1'b1;
                    end else begin
                        time_d.hours = time_q.hours + 1'b1;
                    end
                end else begin
                    time_d.mins = time_q.mins + 1'b1;
                end
            end else begin
                time_d.secs = time_q.secs + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q     <= '0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
        end else begin
            time_q     <= time_d;
            sec_tick_q <= sec_tick_d;
            day_tick_q <= day_tick_d;
        end
    end

    assign time_out = time_q;
    assign sec_tick = sec_tick_q;
    assign day_tick = day_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_counter
//  Description : Self-checking bench for time_counter with CLK_FREQ=4.
//                A seconds-of-day reference model predicts time_out and the
//                tick pulses every cycle; directed steps cover reset, day
//                rollover, invalid load, load on terminal count, run enable
//                and button adjust, followed by randomized stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_time_counter;

    localparam int CLK_FREQ = 4;
    localparam int DAY_SECS = 86400;
`ifdef CLOCK_ADJUST_EN
    localparam bit ADJ = 1'b1;
`else
    localparam bit ADJ = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic        set_time;
    logic [16:0] time_set_in;
    logic        inc_min;
    logic        inc_hour;
    logic [16:0] time_out;
    logic        sec_tick;
    logic        day_tick;

    int checks   = 0;
    int failures = 0;

    // Reference model state: seconds since midnight and prescaler phase
    int tod;
    int phase;
    bit prev_min;
    bit prev_hour;
    bit exp_sec;
    bit exp_day;

    time_counter #(
        .CLK_FREQ (CLK_FREQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .set_time    (set_time),
        .time_set_in (time_set_in),
        .inc_min     (inc_min),
        .inc_hour    (inc_hour),
        .time_out    (time_out),
        .sec_tick    (sec_tick),
        .day_tick    (day_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] pack_hms(input int h, input int m, input int s);
        logic [4:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
        hh = 5'(h);
        mm = 6'(m);
        ss = 6'(s);
        return {hh, mm, ss};
    endfunction

    function automatic logic [16:0] pack_tod(input int t);
        return pack_hms(t / 3600, (t / 60) % 60, t % 60);
    endfunction

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tod       = 0;
        phase     = 0;
        prev_min  = 1'b0;
        prev_hour = 1'b0;
        exp_sec   = 1'b0;
        exp_day   = 1'b0;
    endtask

    // Apply the rules for one clock edge using the inputs the DUT sampled
    task automatic model_step();
        int h;
        int m;
        int s;
        bit load_ok;
        bit rise_m;
        bit rise_h;
        bit tc;
        h       = int'(time_set_in[16:12]);
        m       = int'(time_set_in[11:6]);
        s       = int'(time_set_in[5:0]);
        load_ok = set_time && (h < 24) && (m < 60) && (s < 60);
        rise_m  = ADJ && inc_min && !prev_min;
        rise_h  = ADJ && inc_hour && !prev_hour;
        if (ADJ) begin
            prev_min  = inc_min;
            prev_hour = inc_hour;
        end
        tc      = en && (phase == CLK_FREQ - 1);
        exp_sec = 1'b0;
        exp_day = 1'b0;
        if (load_ok) begin
            tod   = h * 3600 + m * 60 + s;
            phase = 0;
        end else begin
            if (en) phase = (phase + 1) % CLK_FREQ;
            if (rise_m || rise_h) begin
                h = tod / 3600;
                m = (tod / 60) % 60;
                s = tod % 60;
                if (rise_m) m = (m + 1) % 60;
                if (rise_h) h = (h + 1) % 24;
                tod = h * 3600 + m * 60 + s;
            end else if (tc) begin
                exp_day = (tod == DAY_SECS - 1);
                tod     = (tod + 1) % DAY_SECS;
                exp_sec = 1'b1;
            end
        end
    endtask

    // One clock: edge, model update, sample 1 time unit later, compare
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("time_out", time_out, pack_tod(tod));
        check("sec_tick", {16'b0, sec_tick}, {16'b0, exp_sec});
        check("day_tick", {16'b0, day_tick}, {16'b0, exp_day});
    endtask

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        set_time    = 1'b0;
        time_set_in = '0;
        inc_min     = 1'b0;
        inc_hour    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_time", time_out, 17'd0);
        check("reset_sec_tick", {16'b0, sec_tick}, 17'd0);
        rst = 1'b0;
        en  = 1'b1;

        // Async reset mid-count, observed before the next clock edge
        repeat (6) tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_time", time_out, 17'd0);
        check("async_rst_sec_tick", {16'b0, sec_tick}, 17'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Day rollover from 23:59:58
        set_time    = 1'b1;
        time_set_in = pack_hms(23, 59, 58);
        tick();
        set_time = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 4) begin
                check("roll_4_time", time_out, pack_hms(23, 59, 59));
                check("roll_4_day_tick", {16'b0, day_tick}, 17'd0);
            end
        end
        check("roll_8_time", time_out, 17'd0);
        check("roll_8_day_tick", {16'b0, day_tick}, 17'd1);

        // Out-of-range hour load is ignored
        tick();
        set_time    = 1'b1;
        time_set_in = pack_hms(24, 0, 0);
        tick();
        set_time = 1'b0;
        check("bad_load_time", time_out, pack_hms(0, 0, 0));
        repeat (6) tick();

        // Load on the terminal-count edge wins over the advance
        for (int i = 0; i < CLK_FREQ && phase != CLK_FREQ - 1; i++) tick();
        set_time    = 1'b1;
        time_set_in = pack_hms(12, 0, 0);
        tick();
        set_time = 1'b0;
        check("tc_load_time", time_out, pack_hms(12, 0, 0));
        check("tc_load_sec_tick", {16'b0, sec_tick}, 17'd0);
        repeat (4) tick();
        check("tc_load_next_time", time_out, pack_hms(12, 0, 1));
        check("tc_load_next_tick", {16'b0, sec_tick}, 17'd1);

        // Run enable low freezes time and prescaler phase
        set_time    = 1'b1;
        time_set_in = pack_hms(10, 30, 15);
        tick();
        set_time = 1'b0;
        repeat (2) tick();
        en = 1'b0;
        repeat (20) tick();
        check("en_hold_time", time_out, pack_hms(10, 30, 15));
        en = 1'b1;
        repeat (2) tick();
        check("en_resume_time", time_out, pack_hms(10, 30, 16));
        check("en_resume_tick", {16'b0, sec_tick}, 17'd1);

        // Button adjust with the clock stopped
        en          = 1'b0;
        set_time    = 1'b1;
        time_set_in = pack_hms(7, 59, 30);
        tick();
        set_time = 1'b0;
        inc_min  = 1'b1;
        repeat (10) tick();
        inc_min = 1'b0;
        tick();
        check("adj_min_time", time_out, ADJ ? pack_hms(7, 0, 30) : pack_hms(7, 59, 30));
        set_time    = 1'b1;
        time_set_in = pack_hms(23, 15, 30);
        tick();
        set_time = 1'b0;
        inc_hour = 1'b1;
        tick();
        inc_hour = 1'b0;
        tick();
        check("adj_hour_time", time_out, ADJ ? pack_hms(0, 15, 30) : pack_hms(23, 15, 30));
        en = 1'b1;

        // Randomized stimulus against the model
        for (int i = 0; i < 600; i++) begin
            en          = ($urandom_range(0, 9) != 0);
            set_time    = ($urandom_range(0, 24) == 0);
            time_set_in = 17'($urandom);
            if ($urandom_range(0, 3) == 0) time_set_in = pack_hms(23, 59, int'($urandom_range(50, 59)));
            inc_min     = ($urandom_range(0, 11) == 0) ? ~inc_min  : inc_min;
            inc_hour    = ($urandom_range(0, 13) == 0) ? ~inc_hour : inc_hour;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
